// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// The processor top also takes its default bus widths from here.
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;  // wide enough for LATENCY up to 15

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} arb_state_e;
  typedef enum logic {GNT_IF, GNT_MEM} gnt_e;
endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Grant select: MEM (older instruction) wins ties unless IF has waited
// through STARVE_MAX consecutive MEM grants.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          mem_req,
  input  logic [SW-1:0] starve_cnt,
  output gnt_e          gnt
);
  logic if_forced;

  always_comb begin
    if_forced = if_req && (starve_cnt == SW'(STARVE_MAX));
    gnt       = (mem_req && !if_forced) ? GNT_MEM : GNT_IF;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one single-port memory
// with a fixed access latency, and freezes the pipeline while one is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              freeze
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  gnt_e             gnt_sel, gnt_q;
  logic             store_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SW-1:0]    starve_q;
  logic             grant_fire, done_fire;

  // Byte offset is dropped on purpose; misaligned accesses just round down.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], mem_addr[1:0]};

  arb_priority_sel #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_sel (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .starve_cnt (starve_q),
    .gnt        (gnt_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (if_req || mem_req) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_fire = (state_q == ST_IDLE) && (if_req || mem_req);
    done_fire  = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(1));
  end

  // Grant capture, strobe and latency count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q     <= GNT_IF;
      store_q   <= 1'b0;
      cnt_q     <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= grant_fire;
      ram_we <= grant_fire && (gnt_sel == GNT_MEM) && mem_we;
      if (grant_fire) begin
        gnt_q   <= gnt_sel;
        store_q <= (gnt_sel == GNT_MEM) && mem_we;
        cnt_q   <= CNT_W'(LATENCY);
        if (gnt_sel == GNT_MEM) begin
          ram_addr  <= mem_addr[ADDR_W-1:2];
          ram_wdata <= mem_wdata;
        end else begin
          ram_addr  <= if_addr[ADDR_W-1:2];
        end
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Starvation counter only advances on MEM grants that overtook a waiting IF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_fire) begin
      if (gnt_sel == GNT_IF)
        starve_q <= '0;
      else if (if_req && starve_q != SW'(STARVE_MAX))
        starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ready  <= done_fire && (gnt_q == GNT_IF);
      mem_ready <= done_fire && (gnt_q == GNT_MEM);
      if (done_fire && gnt_q == GNT_IF)
        if_rdata <= ram_rdata;
      if (done_fire && gnt_q == GNT_MEM && !store_q)
        mem_rdata <= ram_rdata;
    end
  end

  assign freeze = (if_req && !if_ready) || (mem_req && !mem_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LATENCY=2, STARVE_MAX=4): a vector
// table of single transactions plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, mem_req, mem_we, mem_ready;
  logic        ram_en, ram_we, freeze;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_wdata, ram_rdata;
  logic [29:0] ram_addr;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_if, exp_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .freeze(freeze)
  );

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [29:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after an edge with the arbiter idle; that cycle is cycle 0.
  task automatic run_txn(input vec_t v);
    ram_rdata = v.rdata;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("c0_freeze", freeze, 1);
    chk("c0_ram_en", ram_en, 0);
    step();
    chk("c1_ram_en", ram_en, 1);
    chk("c1_ram_we", ram_we, v.is_mem & v.we);
    chk("c1_ram_addr", ram_addr, v.exp_addr);
    if (v.is_mem && v.we) chk("c1_ram_wdata", ram_wdata, v.wdata);
    if_addr = 32'hFFFF_FFF0; mem_addr = 32'hFFFF_FFF0;
    mem_we = ~mem_we; mem_wdata = ~mem_wdata;
    step();
    chk("c2_ram_en", ram_en, 0);
    chk("c2_ram_we", ram_we, 0);
    chk("c2_ram_addr_held", ram_addr, v.exp_addr);
    chk("c2_freeze", freeze, 1);
    chk("c2_ready", {if_ready, mem_ready}, 0);
    step();
    if (!v.is_mem) exp_if = v.rdata;
    else if (!v.we) exp_mem = v.rdata;
    chk("c3_if_ready", if_ready, !v.is_mem);
    chk("c3_mem_ready", mem_ready, v.is_mem);
    chk("c3_if_rdata", if_rdata, exp_if);
    chk("c3_mem_rdata", mem_rdata, exp_mem);
    chk("c3_freeze", freeze, 0);
    if_req = 1'b0; mem_req = 1'b0;
    step();
    chk("c4_ready", {if_ready, mem_ready}, 0);
    chk("c4_ram_en", ram_en, 0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    ram_rdata = 32'h5A5A_5A5A;
    exp_if = 0; exp_mem = 0;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 30'h4};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678,  32'hAAAA_5555, 30'h8};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,          32'hCAFE_F00D, 30'h8};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D,  32'h5555_0000, 30'h11};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0000_0001, 30'h3FFF_FFFF};

    step();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ready", {if_ready, mem_ready}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Both request together: MEM first, IF right after.
    if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 0; mem_addr = 32'h200;
    ram_rdata = 32'h1111_2222;
    #1;
    chk("sim_c0_freeze", freeze, 1);
    step();
    chk("sim_c1_ram_addr", ram_addr, 30'h80);
    chk("sim_c1_ram_we", ram_we, 0);
    step(); step();
    exp_mem = 32'h1111_2222;
    chk("sim_c3_mem_ready", mem_ready, 1);
    chk("sim_c3_if_ready", if_ready, 0);
    chk("sim_c3_mem_rdata", mem_rdata, exp_mem);
    chk("sim_c3_freeze", freeze, 1);
    mem_req = 0; ram_rdata = 32'h3333_4444;
    step();
    chk("sim_c4_ram_en", ram_en, 0);
    step();
    chk("sim_c5_ram_en", ram_en, 1);
    chk("sim_c5_ram_addr", ram_addr, 30'h40);
    step(); step();
    exp_if = 32'h3333_4444;
    chk("sim_c7_if_ready", if_ready, 1);
    chk("sim_c7_if_rdata", if_rdata, exp_if);
    chk("sim_c7_freeze", freeze, 0);
    if_req = 0;
    step();

    // Starvation: four MEM grants, then IF, then MEM again.
    if_req = 1; if_addr = 32'h300; mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      ram_rdata = 32'hA000_0000 + 32'(k);
      step();
      chk("stv_ram_addr", ram_addr, (k == 4) ? 30'hC0 : 30'h100);
      step(); step();
      if (k == 4) begin
        exp_if = ram_rdata;
        chk("stv_if_ready", if_ready, 1);
        chk("stv_mem_ready", mem_ready, 0);
        chk("stv_if_rdata", if_rdata, exp_if);
      end else begin
        exp_mem = ram_rdata;
        chk("stv_mem_ready", mem_ready, 1);
        chk("stv_if_ready", if_ready, 0);
        chk("stv_mem_rdata", mem_rdata, exp_mem);
      end
      if (k == 5) begin if_req = 0; mem_req = 0; end
      step();
    end

    // Reset in the middle of an IF load.
    if_req = 1; if_addr = 32'h40; ram_rdata = 32'h7777_8888;
    step();
    chk("rma_c1_ram_en", ram_en, 1);
    step();
    rst = 0; if_req = 0;
    #1;
    exp_if = 0; exp_mem = 0;
    chk("rma_ram_en", ram_en, 0);
    chk("rma_ram_addr", ram_addr, 0);
    chk("rma_rdata", {if_rdata, mem_rdata}, 0);
    chk("rma_ready", {if_ready, mem_ready}, 0);
    chk("rma_freeze", freeze, 0);
    step();
    rst = 1;
    #1;
    chk("rma_c3_ready", {if_ready, mem_ready}, 0);
    step();
    chk("rma_c4_ready", {if_ready, mem_ready}, 0);
    chk("rma_c4_ram_en", ram_en, 0);
    run_txn('{1'b0, 1'b0, 32'h44, 32'h0, 32'h9999_0000, 30'h11});

    // IF drops its request mid-access: still completes, no re-grant.
    if_req = 1; if_addr = 32'h80; ram_rdata = 32'hFEED_FACE;
    step();
    chk("drp_c1_ram_en", ram_en, 1);
    step();
    if_req = 0;
    #1;
    chk("drp_c2_freeze", freeze, 0);
    step();
    exp_if = 32'hFEED_FACE;
    chk("drp_c3_if_ready", if_ready, 1);
    chk("drp_c3_if_rdata", if_rdata, exp_if);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("drp_idle", {ram_en, if_ready, mem_ready}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
